// File: rtl/jtframe_rom_pkg.sv
// Shared FSM encoding and helpers for the jtframe ROM read arbiter and its slot caches.
package jtframe_rom_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_RDY = 2'd2
  } rom_state_e;

  localparam int MAX_SLOT = 8;
  localparam int OFFW     = 22;

  // Line tag: a 32-bit line holds four bytes or two 16-bit words
  function automatic logic [31:0] slot_tag(input logic [31:0] addr, input logic is16);
    logic [31:0] t;
    t = is16 ? (addr >> 5'd1) : (addr >> 5'd2);
    return t;
  endfunction

  function automatic logic [OFFW-1:0] slot_offset(input logic [MAX_SLOT*OFFW-1:0] offs,
                                                  input int idx);
    return offs[OFFW*idx +: OFFW];
  endfunction

endpackage

// File: rtl/jtframe_rom_slot.sv
// One-line 32-bit read cache for a single ROM slot: tag/valid/line storage,
// zero-latency hit compare, lane mux and miss (pending) flag.
module jtframe_rom_slot
  import jtframe_rom_pkg::*;
#(
  parameter int AW   = 18,
  parameter bit IS16 = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          fill,
  input  logic [AW-2:0] fill_tag,
  input  logic [31:0]   fill_line,
  output logic          ok,
  output logic [15:0]   dout,
  output logic          pending,
  output logic [AW-2:0] tag
);

  logic          valid_r;
  logic [AW-2:0] tag_r;
  logic [31:0]   line_r;
  logic          hit_s;

  assign tag     = (AW-1)'(slot_tag(32'(addr), IS16));
  assign hit_s   = cs & valid_r & (tag_r == tag);
  assign ok      = hit_s;
  assign pending = cs & ~hit_s;

  // Lane select from the cached line; output is zero unless the slot hits
  always_comb begin
    dout = 16'h0000;
    if (!hit_s) begin
      dout = 16'h0000;
    end else if (IS16) begin
      dout = addr[0] ? line_r[31:16] : line_r[15:0];
    end else begin
      case (addr[1:0])
        2'd0:    dout = {8'h00, line_r[7:0]};
        2'd1:    dout = {8'h00, line_r[15:8]};
        2'd2:    dout = {8'h00, line_r[23:16]};
        2'd3:    dout = {8'h00, line_r[31:24]};
        default: dout = 16'h0000;
      endcase
    end
  end

  // Flush wins over fill so a download never leaves stale lines behind
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      tag_r   <= {(AW-1){1'b0}};
      line_r  <= 32'h0000_0000;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (fill) begin
      valid_r <= 1'b1;
      tag_r   <= fill_tag;
      line_r  <= fill_line;
    end
  end

endmodule

// File: rtl/jtframe_rom_arb.sv
// N-slot ROM read arbiter onto the shared 32-bit SDRAM read port.
// Optional JTFRAME_ROM_STATS_EN adds a saturating grant counter output miss_cnt.
module jtframe_rom_arb
  import jtframe_rom_pkg::*;
#(
  parameter int                  NSLOT   = 4,
  parameter int                  AW      = 18,
  parameter logic [NSLOT-1:0]    DW16    = {NSLOT{1'b0}},
  parameter logic [NSLOT*22-1:0] OFFSETS = {(NSLOT*22){1'b0}},
  parameter bit                  PRIO_RR = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic [NSLOT-1:0]    slot_cs,
  input  logic [NSLOT*AW-1:0] slot_addr,
  output logic [NSLOT-1:0]    slot_ok,
  output logic [NSLOT*16-1:0] slot_dout,
  output logic                sdram_req,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [31:0]         data_read,
  output logic [21:0]         sdram_addr,
  output logic                refresh_en,
  output logic                ready
`ifdef JTFRAME_ROM_STATS_EN
  , output logic [15:0]       miss_cnt
`endif
);

  localparam int IW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam logic [MAX_SLOT*OFFW-1:0] OFFS_ALL = (MAX_SLOT*OFFW)'(OFFSETS);

  rom_state_e    state_r, state_nx_s;
  logic [NSLOT-1:0] pend_s;
  logic [AW-2:0] tag_s [NSLOT];
  logic          any_pend_s, grant_s, fill_go_s;
  logic [IW-1:0] win_s, win_r, ptr_r;
  logic [AW-2:0] sel_tag_s, wtag_r;
  logic [21:0]   sel_off_s, addr_r;
  logic          req_r, discard_r, ready_r;

  assign any_pend_s = |pend_s;
  assign fill_go_s  = (state_r == WAIT_RDY) && data_rdy && !downloading && !discard_r;

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    jtframe_rom_slot #(.AW(AW), .IS16(DW16[i])) u_slot (
      .clk       (clk),
      .rst       (rst),
      .flush     (downloading),
      .cs        (slot_cs[i]),
      .addr      (slot_addr[AW*i +: AW]),
      .fill      (fill_go_s && (win_r == IW'(i))),
      .fill_tag  (wtag_r),
      .fill_line (data_read),
      .ok        (slot_ok[i]),
      .dout      (slot_dout[16*i +: 16]),
      .pending   (pend_s[i]),
      .tag       (tag_s[i])
    );
  end

  // Winner: first pending slot at or after the pointer, else the lowest pending slot
  always_comb begin
    logic found_v, take_v;
    win_s   = {IW{1'b0}};
    found_v = 1'b0;
    take_v  = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      take_v  = !found_v && pend_s[i] && (i >= int'(ptr_r));
      win_s   = take_v ? IW'(i) : win_s;
      found_v = found_v | take_v;
    end
    for (int i = 0; i < NSLOT; i++) begin
      take_v  = !found_v && pend_s[i];
      win_s   = take_v ? IW'(i) : win_s;
      found_v = found_v | take_v;
    end
  end

  // Tag and SDRAM offset of the current winner
  always_comb begin
    sel_tag_s = {(AW-1){1'b0}};
    sel_off_s = 22'h0;
    for (int i = 0; i < NSLOT; i++) begin
      sel_tag_s = (win_s == IW'(i)) ? tag_s[i] : sel_tag_s;
      sel_off_s = (win_s == IW'(i)) ? slot_offset(OFFS_ALL, i) : sel_off_s;
    end
  end

  // Next state and grant decision
  always_comb begin
    state_nx_s = state_r;
    grant_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_pend_s && !downloading) begin
          grant_s    = 1'b1;
          state_nx_s = WAIT_ACK;
        end else begin
          state_nx_s = IDLE;
        end
      end
      WAIT_ACK: begin
        if (sdram_ack) state_nx_s = WAIT_RDY;
        else           state_nx_s = WAIT_ACK;
      end
      WAIT_RDY: begin
        if (data_rdy) state_nx_s = IDLE;
        else          state_nx_s = WAIT_RDY;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx_s;
  end

  // Request, address, latched winner and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      req_r     <= 1'b0;
      addr_r    <= 22'h0;
      win_r     <= {IW{1'b0}};
      wtag_r    <= {(AW-1){1'b0}};
      ptr_r     <= {IW{1'b0}};
      discard_r <= 1'b0;
      ready_r   <= 1'b0;
    end else begin
      if (grant_s) begin
        req_r  <= 1'b1;
        addr_r <= sel_off_s + 22'({sel_tag_s, 1'b0});
        win_r  <= win_s;
        wtag_r <= sel_tag_s;
        if (PRIO_RR) ptr_r <= (win_s == IW'(NSLOT-1)) ? {IW{1'b0}} : win_s + IW'(1);
      end else if ((state_r == WAIT_ACK) && sdram_ack) begin
        req_r <= 1'b0;
      end
      // A transaction that overlaps a download completes but never fills
      if (state_r == IDLE)  discard_r <= 1'b0;
      else if (downloading) discard_r <= 1'b1;
      if (downloading)            ready_r <= 1'b0;
      else if (state_r == IDLE)   ready_r <= 1'b1;
    end
  end

  assign sdram_req  = req_r;
  assign sdram_addr = addr_r;
  assign ready      = ready_r;
  assign refresh_en = rst | ((state_r == IDLE) & ~any_pend_s);

`ifdef JTFRAME_ROM_STATS_EN
  logic dl_prev_r;

  // Saturating grant counter, cleared when a download starts
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_cnt  <= 16'h0000;
      dl_prev_r <= 1'b0;
    end else begin
      dl_prev_r <= downloading;
      if (downloading && !dl_prev_r)            miss_cnt <= 16'h0000;
      else if (grant_s && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'h0001;
    end
  end
`endif

endmodule
